// File: rtl/reg_native_if_initiator.sv
// ---------------------------------------------------------------------------
// reg_native_if_initiator
// Turns single host read/write commands (valid/ready) into one native-bus
// request at a time, waits for the responder's ack_vld (with an optional
// timeout), and returns a response carrying read data and an error flag.
// Misaligned commands can be rejected without touching the native bus.
//
// Ports
//   native_clk, native_rst_n : clock, asynchronous active-low reset
//   soft_rst                 : synchronous reset, same effect as native_rst_n
//   cmd_vld/cmd_rdy          : host command handshake
//   cmd_wr/cmd_addr/cmd_wdata: command type (1 = write), byte address, data
//   resp_vld/resp_rdy        : host response handshake
//   resp_rdata/resp_err      : read data (0 for writes/errors), error flag
//   req_vld/addr/wr_en/rd_en/wr_data : native request, held until done
//   ack_vld/rd_data          : native acknowledge pulse and read data
//   busy                     : transaction in progress (state not IDLE)
// ---------------------------------------------------------------------------
module reg_native_if_initiator #(
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CHECK_ALIGN    = 1
) (
    input  logic                      native_clk,
    input  logic                      native_rst_n,
    input  logic                      soft_rst,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic                      cmd_wr,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      resp_vld,
    input  logic                      resp_rdy,
    output logic [BUS_DATA_WIDTH-1:0] resp_rdata,
    output logic                      resp_err,
    output logic                      req_vld,
    input  logic                      ack_vld,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic                      wr_en,
    output logic                      rd_en,
    output logic [BUS_DATA_WIDTH-1:0] wr_data,
    input  logic [BUS_DATA_WIDTH-1:0] rd_data,
    output logic                      busy
);

    localparam int unsigned BUS_BYTES = BUS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;

    localparam logic [BUS_ADDR_WIDTH-1:0] ALIGN_MASK = BUS_ADDR_WIDTH'(BUS_BYTES - 1);
    localparam logic [CNT_W-1:0]          CNT_LAST   = CNT_W'(CNT_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      cmd_rdy_q;
    logic                      resp_vld_q;
    logic [BUS_DATA_WIDTH-1:0] resp_rdata_q;
    logic                      resp_err_q;
    logic                      req_vld_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic                      wr_en_q;
    logic                      rd_en_q;
    logic [BUS_DATA_WIDTH-1:0] wr_data_q;
    logic                      busy_q;

    logic cmd_misaligned;
    logic tmo_hit;

    // Low address bits below the bus width must be zero when checking is on
    assign cmd_misaligned = (CHECK_ALIGN != 0) && ((cmd_addr & ALIGN_MASK) != '0);

    // Terminal count: this WAIT cycle is the last one allowed without an ack
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Transaction FSM with all outputs registered
    always_ff @(posedge native_clk or negedge native_rst_n) begin
        if (!native_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_rdy_q    <= 1'b1;
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_vld_q    <= 1'b0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
        end else if (soft_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_rdy_q    <= 1'b1;
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_vld_q    <= 1'b0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_vld && cmd_rdy_q) begin
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (cmd_misaligned) begin
                            // Rejected without any native activity
                            state_q      <= ST_RESP;
                            resp_vld_q   <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q   <= ST_WAIT;
                            cnt_q     <= '0;
                            req_vld_q <= 1'b1;
                            addr_q    <= cmd_addr;
                            wr_en_q   <= cmd_wr;
                            rd_en_q   <= ~cmd_wr;
                            wr_data_q <= cmd_wr ? cmd_wdata : '0;
                        end
                    end
                end

                ST_WAIT: begin
                    // Ack takes precedence over a simultaneous timeout
                    if (ack_vld || tmo_hit) begin
                        state_q      <= ST_RESP;
                        req_vld_q    <= 1'b0;
                        addr_q       <= '0;
                        wr_en_q      <= 1'b0;
                        rd_en_q      <= 1'b0;
                        wr_data_q    <= '0;
                        resp_vld_q   <= 1'b1;
                        resp_err_q   <= ~ack_vld;
                        resp_rdata_q <= (ack_vld && rd_en_q) ? rd_data : '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (resp_rdy) begin
                        state_q      <= ST_IDLE;
                        resp_vld_q   <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        cmd_rdy_q    <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cmd_rdy_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_rdy    = cmd_rdy_q;
    assign resp_vld   = resp_vld_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign req_vld    = req_vld_q;
    assign addr       = addr_q;
    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reg_native_if_initiator.sv
// ---------------------------------------------------------------------------
// tb_reg_native_if_initiator
// Directed bench: stimulus tasks push expected responses into a queue and a
// negedge monitor pops/compares them at every response handshake. Native-bus
// timing, stability, timeout and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_reg_native_if_initiator;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned TO = 8;

    logic          native_clk;
    logic          native_rst_n;
    logic          soft_rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          resp_vld;
    logic          resp_rdy;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          req_vld;
    logic          ack_vld;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;

    reg_native_if_initiator #(
        .BUS_DATA_WIDTH(DW),
        .BUS_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO),
        .CHECK_ALIGN   (1)
    ) dut (
        .native_clk  (native_clk),
        .native_rst_n(native_rst_n),
        .soft_rst    (soft_rst),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .resp_vld    (resp_vld),
        .resp_rdy    (resp_rdy),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .req_vld     (req_vld),
        .ack_vld     (ack_vld),
        .addr        (addr),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    initial native_clk = 1'b0;
    always #5 native_clk = ~native_clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0] sb_q[$];   // {err, rdata}

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge native_clk);
        #1;
    endtask

    // {cmd_rdy, resp_vld, req_vld, wr_en, rd_en, busy, resp_err, |addr, |wr_data, |resp_rdata}
    task automatic check_idle(input string nm);
        check(nm, 128'({cmd_rdy, resp_vld, req_vld, wr_en, rd_en, busy, resp_err,
                        |addr, |wr_data, |resp_rdata}), 128'(10'b10_0000_0000));
    endtask

    // Response monitor: every handshake must match the oldest expectation
    always @(negedge native_clk) begin
        if (native_rst_n && resp_vld && resp_rdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 128'({resp_err, resp_rdata}), 128'(0));
            end else begin
                check("resp_payload", 128'({resp_err, resp_rdata}), 128'(sb_q.pop_front()));
            end
        end
    end

    // Issue one command, play the responder (ack after ack_dly request cycles,
    // -1 = never), check native timing, then hold the response for hold cycles.
    task automatic do_cmd(input string nm, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int ack_dly, input logic [DW-1:0] rd,
                          input logic [DW-1:0] exp_rdata, input logic exp_err,
                          input int exp_reqc, input int exp_lat, input int hold);
        int lat;
        int reqc;
        logic [DW-1:0] exp_wd;
        exp_wd = wr ? wd : '0;
        sb_q.push_back({exp_err, exp_rdata});
        resp_rdy  = (hold == 0);
        cmd_vld   = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        check({nm, "_cmd_rdy"}, 128'(cmd_rdy), 128'(1));
        tick();
        cmd_vld   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        lat  = 1;
        reqc = 0;
        while (!resp_vld && lat < 60) begin
            check({nm, "_wait_flags"}, 128'({cmd_rdy, busy, req_vld}), 128'(3'b011));
            check({nm, "_req_fields"}, 128'({wr_en, rd_en, addr, wr_data}),
                  128'({wr, ~wr, a, exp_wd}));
            ack_vld = (reqc == ack_dly);
            rd_data = ack_vld ? rd : DW'($urandom);
            reqc++;
            tick();
            ack_vld = 1'b0;
            rd_data = DW'($urandom);
            lat++;
        end
        check({nm, "_latency"}, 128'(lat), 128'(exp_lat));
        check({nm, "_req_cycles"}, 128'(reqc), 128'(exp_reqc));
        check({nm, "_native_idle"}, 128'({req_vld, wr_en, rd_en, |addr, |wr_data}), 128'(0));
        for (int i = 0; i < hold; i++) begin
            check({nm, "_hold"}, 128'({cmd_rdy, resp_vld, resp_err, resp_rdata}),
                  128'({1'b0, 1'b1, exp_err, exp_rdata}));
            // stray ack while a response is pending must be ignored
            ack_vld = (i == 1);
            tick();
            ack_vld = 1'b0;
        end
        resp_rdy = 1'b1;
        tick();
        check_idle({nm, "_back_idle"});
    endtask

    initial begin
        native_rst_n = 1'b0;
        soft_rst     = 1'b0;
        cmd_vld      = 1'b0;
        cmd_wr       = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        resp_rdy     = 1'b1;
        ack_vld      = 1'b0;
        rd_data      = '0;
        #23;
        check_idle("reset_state");
        native_rst_n = 1'b1;
        tick();
        check_idle("after_reset");

        // Write, ack 3 cycles after req rises; rd_data on ack must not leak
        do_cmd("wr_ack3", 1'b1, 64'h10, 32'hDEADBEEF, 3, 32'h5555AAAA, 32'h0, 1'b0, 4, 5, 0);
        // Read acked in the same cycle req rises
        do_cmd("rd_ack0", 1'b0, 64'h20, 32'hFFFFFFFF, 0, 32'h12345678, 32'h12345678, 1'b0, 1, 2, 0);
        // Timeout without ack
        do_cmd("rd_tmo", 1'b0, 64'h30, 32'h0, -1, 32'h0, 32'h0, 1'b1, 8, 9, 0);
        // Late ack two cycles later is ignored
        tick();
        ack_vld = 1'b1;
        rd_data = 32'hBADBAD00;
        tick();
        ack_vld = 1'b0;
        tick();
        check_idle("late_ack_ignored");
        check("late_ack_no_pending", 128'(sb_q.size()), 128'(0));
        // Next read returns its own data
        do_cmd("rd_after_tmo", 1'b0, 64'h40, 32'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2, 3, 0);
        // Ack on the timeout terminal cycle wins
        do_cmd("rd_ack_at_tc", 1'b0, 64'h48, 32'h0, 7, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 8, 9, 0);
        // Misaligned address rejected
        do_cmd("misaligned", 1'b1, 64'h13, 32'h11111111, 0, 32'h0, 32'h0, 1'b1, 0, 1, 0);
        do_cmd("misaligned2", 1'b0, 64'h102, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0, 1, 0);
        // Response back-pressure for 5 cycles
        do_cmd("rd_hold", 1'b0, 64'h80, 32'h0, 2, 32'hA5A5F00F, 32'hA5A5F00F, 1'b0, 3, 4, 5);
        do_cmd("wr_hold", 1'b1, 64'hFFFF_0000_0000_0004, 32'h01020304, 0, 32'h77777777,
               32'h0, 1'b0, 1, 2, 5);

        // soft_rst two cycles into WAIT aborts with no response
        cmd_vld  = 1'b1;
        cmd_wr   = 1'b0;
        cmd_addr = 64'h200;
        tick();
        cmd_vld  = 1'b0;
        cmd_addr = '0;
        tick();
        check("softrst_pre_req", 128'({req_vld, busy}), 128'(2'b11));
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check_idle("softrst_abort");
        for (int i = 0; i < 3; i++) tick();
        check_idle("softrst_no_resp");

        // Async reset mid-cycle clears outputs without a clock edge
        cmd_vld   = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 64'h300;
        cmd_wdata = 32'h99999999;
        tick();
        cmd_vld   = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        tick();
        check("arst_pre_req", 128'({req_vld, wr_en}), 128'(2'b11));
        #2;
        native_rst_n = 1'b0;
        #1;
        check_idle("arst_async_clear");
        #3;
        native_rst_n = 1'b1;
        tick();
        check_idle("arst_released");

        // Recovery after resets
        do_cmd("wr_recover", 1'b1, 64'h400, 32'h0F0F0F0F, 2, 32'h0, 32'h0, 1'b0, 3, 4, 0);
        tick();
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_native_if_initiator.md
Name: reg_native_if_initiator

Overview:
Native-register-interface initiator. It accepts single read/write commands from a host-side valid/ready channel and drives the native bus (req_vld/addr/wr_en/rd_en/wr_data). It waits for ack_vld/rd_data from the downstream responder, such as a native-to-memory bridge or a register block, and returns a response with an error flag. One outstanding transaction at a time, with an optional timeout and an alignment check.

Parameters:
BUS_DATA_WIDTH, 32, native data width; must be a power of 2 and at least 8
BUS_ADDR_WIDTH, 64, native byte-address width
TIMEOUT_CYCLES, 256, maximum wait for ack_vld after req_vld asserts; 0 disables the timeout
CHECK_ALIGN, 1, 1 = reject commands whose address is not aligned to BUS_DATA_WIDTH/8 bytes

Ports:
native_clk  in  1  clock
native_rst_n  in  1  reset, asynchronous, active-low
soft_rst  in  1  synchronous reset, same effect as native_rst_n
cmd_vld  in  1  host command valid
cmd_rdy  out  1  host command ready
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  BUS_ADDR_WIDTH  byte address
cmd_wdata  in  BUS_DATA_WIDTH  write data
resp_vld  out  1  response valid
resp_rdy  in  1  response ready
resp_rdata  out  BUS_DATA_WIDTH  read data; 0 for writes and errors
resp_err  out  1  1 = timeout or misaligned
req_vld  out  1  native request, level
ack_vld  in  1  native acknowledge, 1-cycle pulse
addr  out  BUS_ADDR_WIDTH  native address
wr_en  out  1  native write enable
rd_en  out  1  native read enable
wr_data  out  BUS_DATA_WIDTH  native write data
rd_data  in  BUS_DATA_WIDTH  native read data, valid with ack_vld
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Clock is native_clk. Reset is native_rst_n, asynchronous, active-low. soft_rst is synchronous and takes priority over every other event.
- All outputs are registered.
- Reset values: every output 0, except cmd_rdy=1; state=IDLE; timeout counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cmd_rdy=1. A command is accepted when cmd_vld&cmd_rdy.
  - If CHECK_ALIGN and cmd_addr[log2(BUS_DATA_WIDTH/8)-1:0]!=0: go to RESP with resp_err=1 and resp_rdata=0. No native request is issued.
  - Otherwise: go to WAIT. On the next cycle req_vld=1, addr=cmd_addr, wr_en=cmd_wr, rd_en=~cmd_wr, wr_data=cmd_wdata (0 for reads). Counter is cleared.
  - Latency from acceptance to req_vld high is 1 cycle.
- WAIT:
  - cmd_rdy=0. req_vld, addr, wr_en, rd_en and wr_data are held stable until completion.
  - Completion on a clock edge with ack_vld=1: the next cycle drops req_vld/wr_en/rd_en to 0, zeroes addr/wr_data, and enters RESP.
    - Read: resp_rdata captures rd_data at the ack edge.
    - Write: resp_rdata=0.
    - resp_err=0.
  - An ack in the same cycle req_vld first rises is valid and completes.
  - Minimum round trip, accept to resp_vld: 2 cycles.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack, the next cycle deasserts the native signals and enters RESP with resp_err=1 and resp_rdata=0.
  - If ack_vld and the timeout terminal count occur in the same cycle, ack wins and resp_err=0.
  - With TIMEOUT_CYCLES=0 the block waits indefinitely.
- RESP:
  - resp_vld=1, with resp_rdata and resp_err stable until resp_vld&resp_rdy.
  - Then resp_vld=0 and the block returns to IDLE with cmd_rdy=1 on the next cycle. No back-to-back overlap: the earliest next acceptance is the cycle after the handshake.
- ack_vld in IDLE or RESP (stray or late after a timeout) is ignored. It is never attributed to a later command.
- Reset or soft_rst mid-transaction aborts immediately: req_vld=0, no response, IDLE.
- wr_en and rd_en are never both 1, and are 0 whenever req_vld=0.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
1. Write cmd addr=0x10, wdata=0xDEADBEEF; responder acks 3 cycles after req_vld -> req_vld high exactly 4 cycles with wr_en=1, rd_en=0, wr_data stable; then resp_vld=1, resp_err=0, resp_rdata=0.
2. Read cmd addr=0x20; responder acks in the same cycle req_vld rises with rd_data=0x12345678 -> resp_rdata=0x12345678, resp_err=0; resp_vld exactly 2 cycles after acceptance.
3. TIMEOUT_CYCLES=8, no ack -> req_vld high 8 cycles then low; resp_err=1, resp_rdata=0. A late ack 2 cycles later is ignored, and the next read returns its own ack data.
4. CHECK_ALIGN=1, addr=0x13 -> req_vld never asserts; resp_vld with resp_err=1 one cycle after acceptance.
5. Hold resp_rdy=0 for 5 cycles -> resp_vld, resp_rdata and resp_err stable; cmd_rdy=0 throughout; cmd_rdy=1 the cycle after resp_rdy=1.
6. Assert soft_rst 2 cycles into WAIT -> next cycle req_vld=0, busy=0, cmd_rdy=1, no resp_vld. Repeat with native_rst_n asserted asynchronously mid-cycle -> outputs clear without a clock edge.
